// File: rtl/ones_decode_pkg.sv
// Shared types for the ones'-complement to two's-complement decoder.
package ones_decode_pkg;
   localparam int ONES_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/serial_add1_cell.sv
// Half-adder step used by bit-serial arithmetic.
module serial_add1_cell (
   input  logic a,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ cin;
   assign cout = a & cin;
endmodule

// File: rtl/ones_decode.sv
// Ones'-complement to two's-complement decoder using a bit-serial
// +1 incrementer; one word in flight, valid/ready on both sides.
module ones_decode
   import ones_decode_pkg::*;
#(
   parameter int WIDTH = ONES_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] i,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             neg_zero
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_sr;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic             r_nz;
   logic             r_live;
   logic             w_s;
   logic             w_cout;
   logic             w_acc;

   serial_add1_cell u_add (
      .a    (r_sr[0]),
      .cin  (r_c),
      .s    (w_s),
      .cout (w_cout)
   );

   assign w_acc = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_acc) w_next = S_RUN;
         S_RUN:  if (r_cnt == LAST) w_next = S_DONE;
         S_DONE: if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // r_live keeps in_ready low while reset is asserted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sr   <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_nz   <= 1'b0;
         r_live <= 1'b0;
      end else begin
         r_live <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_acc) begin
                  r_sr  <= i;
                  r_c   <= i[WIDTH-1];
                  r_nz  <= &i;
                  r_cnt <= '0;
               end
            end
            S_RUN: begin
               r_sr <= {w_s, r_sr[WIDTH-1:1]};
               r_c  <= w_cout;
               if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_live & (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign o         = out_valid ? r_sr : '0;
   assign neg_zero  = out_valid & r_nz;
endmodule

// File: tb/tb_ones_decode.sv
// Directed bench for ones_decode at WIDTH=8 plus a WIDTH=4 sweep.
module tb_ones_decode;
   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] i;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] o;
   logic       neg_zero;

   logic       in4_valid;
   logic       in4_ready;
   logic [3:0] i4;
   logic       out4_valid;
   logic       out4_ready;
   logic [3:0] o4;
   logic       nz4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   ones_decode #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .i         (i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .neg_zero  (neg_zero)
   );

   ones_decode #(.WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in4_valid),
      .in_ready  (in4_ready),
      .i         (i4),
      .out_valid (out4_valid),
      .out_ready (out4_ready),
      .o         (o4),
      .neg_zero  (nz4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one word through the 8-bit unit; no checking here
   task automatic do_word8(input logic [7:0] x, output int lat,
                           output logic [7:0] ro, output logic rnz,
                           output int leak);
      in_valid = 1'b1;
      i        = x;
      tick();
      in_valid = 1'b0;
      i        = 8'($urandom);
      lat      = 0;
      leak     = 0;
      while (!out_valid && lat < 40) begin
         if (o !== 8'h00 || neg_zero !== 1'b0) leak++;
         tick();
         lat++;
      end
      ro  = o;
      rnz = neg_zero;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      i = 8'h00;
      in4_valid = 1'b0;
      out4_ready = 1'b0;
      i4 = 4'h0;
      tick();
      tick();
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_ready got=%b want=0", in_ready);
      end
      total++;
      if (out_valid !== 1'b0 || o !== 8'h00 || neg_zero !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs got=%b/%h/%b want=0/00/0",
                  out_valid, o, neg_zero);
      end
      rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
      end
   endtask

   task automatic test_positive();
      int lat, leak;
      logic [7:0] ro;
      logic rnz;
      do_word8(8'h25, lat, ro, rnz, leak);
      total++;
      if (lat !== 8) begin
         bad++;
         $display("FAIL pos_latency got=%0d want=8", lat);
      end
      total++;
      if (ro !== 8'h25 || rnz !== 1'b0) begin
         bad++;
         $display("FAIL pos_value got=%h/%b want=25/0", ro, rnz);
      end
      total++;
      if (leak !== 0) begin
         bad++;
         $display("FAIL pos_mask got=%0d want=0", leak);
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL pos_ready_after got=%b want=1", in_ready);
      end
   endtask

   task automatic test_negative();
      int lat, leak;
      logic [7:0] ro;
      logic rnz;
      do_word8(8'hFA, lat, ro, rnz, leak);
      total++;
      if (ro !== 8'hFB || rnz !== 1'b0 || lat !== 8) begin
         bad++;
         $display("FAIL neg_fa got=%h/%b/%0d want=fb/0/8", ro, rnz, lat);
      end
      do_word8(8'h80, lat, ro, rnz, leak);
      total++;
      if (ro !== 8'h81 || rnz !== 1'b0 || lat !== 8) begin
         bad++;
         $display("FAIL neg_80 got=%h/%b/%0d want=81/0/8", ro, rnz, lat);
      end
      total++;
      if (leak !== 0) begin
         bad++;
         $display("FAIL neg_mask got=%0d want=0", leak);
      end
   endtask

   task automatic test_zeros();
      int lat, leak;
      logic [7:0] ro;
      logic rnz;
      do_word8(8'hFF, lat, ro, rnz, leak);
      total++;
      if (ro !== 8'h00 || rnz !== 1'b1) begin
         bad++;
         $display("FAIL neg_zero got=%h/%b want=00/1", ro, rnz);
      end
      total++;
      if (leak !== 0) begin
         bad++;
         $display("FAIL neg_zero_mask got=%0d want=0", leak);
      end
      do_word8(8'h00, lat, ro, rnz, leak);
      total++;
      if (ro !== 8'h00 || rnz !== 1'b0) begin
         bad++;
         $display("FAIL pos_zero got=%h/%b want=00/0", ro, rnz);
      end
   endtask

   task automatic test_backpressure();
      int n;
      in_valid = 1'b1;
      i = 8'h3C;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (n !== 8) begin
         bad++;
         $display("FAIL bp_latency got=%0d want=8", n);
      end
      in_valid = 1'b1;
      i = 8'h11;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (o !== 8'h3C || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold k=%0d got=%h/%b/%b want=3c/0/1",
                     k, o, in_ready, out_valid);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_release got=%b/%b want=1/0", in_ready, out_valid);
      end
      tick();
      in_valid = 1'b0;
      i = 8'hAA;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL bp_accept got=%b want=0", in_ready);
      end
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
      end
      total++;
      if (o !== 8'h11 || n !== 8) begin
         bad++;
         $display("FAIL bp_next got=%h/%0d want=11/8", o, n);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int seen;
      in_valid = 1'b1;
      i = 8'hF0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      total++;
      if (out_valid !== 1'b0 || o !== 8'h00 || neg_zero !== 1'b0 ||
          in_ready !== 1'b0) begin
         bad++;
         $display("FAIL midrst_outs got=%b/%h/%b/%b want=0/00/0/0",
                  out_valid, o, neg_zero, in_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL midrst_ready got=%b want=1", in_ready);
      end
      out_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         if (out_valid) seen++;
         tick();
      end
      out_ready = 1'b0;
      total++;
      if (seen !== 0) begin
         bad++;
         $display("FAIL midrst_no_result got=%0d want=0", seen);
      end
   endtask

   task automatic test_sweep4();
      logic [3:0] v;
      logic [3:0] exp;
      int prev, n;
      out4_ready = 1'b1;
      in4_valid = 1'b1;
      prev = 0;
      for (int k = 0; k < 16; k++) begin
         v = 4'(k);
         i4 = v;
         n = 0;
         while (!in4_ready && n < 20) begin
            tick();
            n++;
         end
         if (k > 0) begin
            total++;
            if (cyc - prev !== 6) begin
               bad++;
               $display("FAIL sweep_spacing v=%h got=%0d want=6",
                        v, cyc - prev);
            end
         end
         prev = cyc;
         tick();
         n = 0;
         while (!out4_valid && n < 20) begin
            tick();
            n++;
         end
         exp = v[3] ? v + 4'd1 : v;
         total++;
         if (o4 !== exp || nz4 !== (v == 4'hF)) begin
            bad++;
            $display("FAIL sweep_value v=%h got=%h/%b want=%h/%b",
                     v, o4, nz4, exp, (v == 4'hF));
         end
         tick();
      end
      in4_valid = 1'b0;
      out4_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_positive();
      test_negative();
      test_zeros();
      test_backpressure();
      test_reset_mid_run();
      test_sweep4();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
